alu_logic_unit: RTL

//  Parametrised multi-function bitwise logic unit for the ALU logical group.

---
 rtl/alu_logic_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_logic_unit.sv
// ============================================================================
// Module      : alu_logic_unit
// Description : Eight-function bitwise logic unit with a start/done handshake,
//               zero/parity flags and a zero-extended 2*WIDTH result bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   res,
    output logic                 zero,
    output logic                 parity,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_ANDN = 3'b111;

    logic [1:0]       state_q,  state_d;
    logic [2:0]       op_q,     op_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             zero_q,   zero_d;
    logic             parity_q, parity_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] w_result;

    // The function operates on the latched operands so input changes after acceptance are harmless.
    always_comb begin
        w_result = '0;
        case (op_q)
            OP_AND:  w_result = a_q & b_q;
            OP_OR:   w_result = a_q | b_q;
            OP_XOR:  w_result = a_q ^ b_q;
            OP_NAND: w_result = ~(a_q & b_q);
            OP_NOR:  w_result = ~(a_q | b_q);
            OP_XNOR: w_result = ~(a_q ^ b_q);
            OP_NOTA: w_result = ~a_q;
            OP_ANDN: w_result = a_q & ~b_q;
            default: w_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d    = w_result;
                zero_d   = ~|w_result;
                parity_d = ^w_result;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    assign res    = {{WIDTH{1'b0}}, res_q};
    assign zero   = zero_q;
    assign parity = parity_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;

endmodule

`default_nettype wire
